// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 64-point SDF FFT pipeline stages:
//   - default component / twiddle widths
//   - per-sample stage codes produced by the twiddle ROM
//   - Q8 unity constant for twiddle factors
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int DATA_W_DEF    = 24;
  localparam int FRAC_BITS_DEF = 8;
  localparam int DELAY_DEF     = 8;

  // Twiddle value representing +1.0 in Q8
  localparam int ONE = 256;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_BFLY = 2'd1,
    ST_TWID = 2'd2,
    ST_RSVD = 2'd3
  } st_e;

endpackage

// File: rtl/fft_cmult.sv
// -----------------------------------------------------------------------------
// fft_cmult
// Purely combinational complex multiply shared by the SDF stages.
//   o_p = (i_a * i_b) >>> FRAC_BITS, each component truncated to DATA_W bits.
// Products are kept at full 2*DATA_W width; the shift is arithmetic (floor).
// Ports:
//   i_a_r, i_a_i  DATA_W  signed multiplicand (data sample)
//   i_b_r, i_b_i  DATA_W  signed multiplier (twiddle, Q(FRAC_BITS))
//   o_p_r, o_p_i  DATA_W  signed product
// -----------------------------------------------------------------------------
module fft_cmult
  import fft_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic [DATA_W-1:0] i_a_r,
  input  logic [DATA_W-1:0] i_a_i,
  input  logic [DATA_W-1:0] i_b_r,
  input  logic [DATA_W-1:0] i_b_i,
  output logic [DATA_W-1:0] o_p_r,
  output logic [DATA_W-1:0] o_p_i
);

  logic signed [2*DATA_W-1:0] w_rr;
  logic signed [2*DATA_W-1:0] w_ii;
  logic signed [2*DATA_W-1:0] w_ri;
  logic signed [2*DATA_W-1:0] w_ir;
  logic signed [2*DATA_W-1:0] w_re;
  logic signed [2*DATA_W-1:0] w_im;

  assign w_rr = $signed(i_a_r) * $signed(i_b_r);
  assign w_ii = $signed(i_a_i) * $signed(i_b_i);
  assign w_ri = $signed(i_a_r) * $signed(i_b_i);
  assign w_ir = $signed(i_a_i) * $signed(i_b_r);

  assign w_re = w_rr - w_ii;
  assign w_im = w_ri + w_ir;

  // Arithmetic shift floors toward -inf; the cast keeps the low DATA_W bits
  assign o_p_r = DATA_W'(w_re >>> FRAC_BITS);
  assign o_p_i = DATA_W'(w_im >>> FRAC_BITS);

endmodule

// File: rtl/fft_sdf_bf_stage.sv
// -----------------------------------------------------------------------------
// fft_sdf_bf_stage
// Radix-2 single-path delay-feedback butterfly stage (feedback depth DELAY).
// Each accepted sample reads the delay-line head and overwrites the same slot:
//   state 0/3 fill      : push din, no output
//   state 1   butterfly : output head+din, push head-din
//   state 2   twiddle   : output head*w, push din
// Outputs are registered, one cycle after the accepting edge.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          sample present (qualifies all state updates)
//   din_r, din_i      DATA_W signed input sample
//   state             ROM stage code for the current sample
//   w_r, w_i          DATA_W signed twiddle, Q(FRAC_BITS)
//   out_valid         dout_* holds a fresh sample
//   dout_r, dout_i    DATA_W signed output sample (held when not valid)
// -----------------------------------------------------------------------------
module fft_sdf_bf_stage
  import fft_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DELAY     = DELAY_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] din_r,
  input  logic [DATA_W-1:0] din_i,
  input  logic [1:0]        state,
  input  logic [DATA_W-1:0] w_r,
  input  logic [DATA_W-1:0] w_i,
  output logic              out_valid,
  output logic [DATA_W-1:0] dout_r,
  output logic [DATA_W-1:0] dout_i
);

  localparam int PTR_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DELAY - 1);

  logic [DATA_W-1:0] r_dl_r [DELAY];
  logic [DATA_W-1:0] r_dl_i [DELAY];
  logic [PTR_W-1:0]  r_ptr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_dout_r;
  logic [DATA_W-1:0] r_dout_i;

  logic [DATA_W-1:0] w_head_r;
  logic [DATA_W-1:0] w_head_i;
  logic [DATA_W-1:0] w_sum_r;
  logic [DATA_W-1:0] w_sum_i;
  logic [DATA_W-1:0] w_diff_r;
  logic [DATA_W-1:0] w_diff_i;
  logic [DATA_W-1:0] w_prod_r;
  logic [DATA_W-1:0] w_prod_i;
  logic [DATA_W-1:0] w_push_r;
  logic [DATA_W-1:0] w_push_i;
  logic [DATA_W-1:0] w_res_r;
  logic [DATA_W-1:0] w_res_i;
  logic              w_emit;
  logic [PTR_W-1:0]  w_ptr_nxt;

  // Oldest entry of the feedback line is the slot about to be overwritten
  assign w_head_r = r_dl_r[r_ptr];
  assign w_head_i = r_dl_i[r_ptr];

  // DATA_W-bit wrapping add/sub, no growth
  assign w_sum_r  = w_head_r + din_r;
  assign w_sum_i  = w_head_i + din_i;
  assign w_diff_r = w_head_r - din_r;
  assign w_diff_i = w_head_i - din_i;

  fft_cmult #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_cmult (
    .i_a_r (w_head_r),
    .i_a_i (w_head_i),
    .i_b_r (w_r),
    .i_b_i (w_i),
    .o_p_r (w_prod_r),
    .o_p_i (w_prod_i)
  );

  // Pointer advance, wrapping at DELAY (DELAY need not be a power of two)
  always_comb begin
    if (r_ptr == PTR_LAST) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = r_ptr + PTR_W'(1);
    end
  end

  // Per-state selection of the value pushed back and the value emitted
  always_comb begin
    w_push_r = din_r;
    w_push_i = din_i;
    w_res_r  = w_sum_r;
    w_res_i  = w_sum_i;
    w_emit   = 1'b0;
    case (state)
      ST_FILL: begin
        w_emit = 1'b0;
      end
      ST_BFLY: begin
        w_push_r = w_diff_r;
        w_push_i = w_diff_i;
        w_res_r  = w_sum_r;
        w_res_i  = w_sum_i;
        w_emit   = 1'b1;
      end
      ST_TWID: begin
        w_res_r = w_prod_r;
        w_res_i = w_prod_i;
        w_emit  = 1'b1;
      end
      ST_RSVD: begin
        w_emit = 1'b0;
      end
      default: begin
        w_emit = 1'b0;
      end
    endcase
  end

  // Feedback delay line and its read/write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DELAY; k++) begin
        r_dl_r[k] <= '0;
        r_dl_i[k] <= '0;
      end
      r_ptr <= '0;
    end else if (in_valid) begin
      r_dl_r[r_ptr] <= w_push_r;
      r_dl_i[r_ptr] <= w_push_i;
      r_ptr         <= w_ptr_nxt;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Registered outputs; dout holds its last value whenever nothing is emitted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_dout_r    <= '0;
      r_dout_i    <= '0;
    end else if (in_valid) begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_dout_r <= w_res_r;
        r_dout_i <= w_res_i;
      end else begin
        r_dout_r <= r_dout_r;
        r_dout_i <= r_dout_i;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign dout_r    = r_dout_r;
  assign dout_i    = r_dout_i;

endmodule
